// File: rtl/db_event_arbiter.sv
// Purpose : turns debounced button levels into press/release/long-press events
//           and multiplexes them onto one valid/ready port (round-robin).
// Latency : 2 cycles from first high sample to evt_valid; peak 1 event / 2 cycles.
// Backpressure: evt_ready=0 holds the presented event; capture continues and a
//           repeat event on an already-pending flag is merged and flagged in ovf.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   btn_db[N_BTN]       debounced levels (1 = pressed), synchronous to clk
//   evt_valid/evt_ready event handshake
//   evt_ch              channel of the presented event
//   evt_type            00 press, 01 release, 10 long-press
//   ovf[N_BTN]          sticky per-channel event-lost flag
module db_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int LONG_LIMIT = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_db,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_ch,
  output logic [1:0]               evt_type,
  output logic [N_BTN-1:0]         ovf
);

  localparam int IW = $clog2(N_BTN);
  localparam int CW = $clog2(LONG_LIMIT + 1);

  localparam logic [CW-1:0] LIMIT_C  = CW'(LONG_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(LONG_LIMIT - 1);
  localparam logic [IW-1:0] LAST_CH  = IW'(N_BTN - 1);
  localparam logic [IW:0]   N_EXT    = (IW+1)'(N_BTN);

  localparam logic [1:0] T_PRESS = 2'b00;
  localparam logic [1:0] T_REL   = 2'b01;
  localparam logic [1:0] T_LONG  = 2'b10;

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic              evt_valid_q;
  logic [IW-1:0]     evt_ch_q;
  logic [1:0]        evt_type_q;
  logic [IW-1:0]     rr_ptr_q;

  logic [N_BTN-1:0]  prev_q;
  logic [N_BTN-1:0]  p_press_q, p_press_d;
  logic [N_BTN-1:0]  p_rel_q,   p_rel_d;
  logic [N_BTN-1:0]  p_long_q,  p_long_d;
  logic [N_BTN-1:0]  ovf_q,     ovf_d;
  logic [CW-1:0]     hold_cnt_q [N_BTN];
  logic [CW-1:0]     hold_cnt_d [N_BTN];

  // ---------------------------------------------------------------------------
  // Per-channel edge detect and hold counting
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0]  rise, fall, long_hit;

  always_comb begin
    rise       = '0;
    fall       = '0;
    long_hit   = '0;
    hold_cnt_d = hold_cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      rise[i] = btn_db[i] & ~prev_q[i];
      fall[i] = ~btn_db[i] & prev_q[i];
      // Only the LONG_LIMIT-1 -> LONG_LIMIT step fires; saturation keeps it
      // from re-firing for the rest of the hold.
      long_hit[i] = btn_db[i] && (hold_cnt_q[i] == LIMIT_M1);
      if (!btn_db[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] < LIMIT_C) begin
        hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester at or after rr_ptr, wrapping at N_BTN
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0]  req;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [IW:0]       cand;

  always_comb begin
    req     = p_press_q | p_rel_q | p_long_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      // One extra bit so the sum cannot alias before the explicit wrap,
      // which keeps non-power-of-two channel counts correct.
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!gnt_vld && req[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Type select for the granted channel and the matching flag clear.
  // Clears only happen on the IDLE grant edge.
  // ---------------------------------------------------------------------------
  logic [1:0]        gnt_type;
  logic [N_BTN-1:0]  clr_press, clr_rel, clr_long;

  always_comb begin
    gnt_type  = T_PRESS;
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    if (state_q == S_IDLE && gnt_vld) begin
      if (p_press_q[gnt_idx]) begin
        gnt_type           = T_PRESS;
        clr_press[gnt_idx] = 1'b1;
      end else if (p_long_q[gnt_idx]) begin
        gnt_type          = T_LONG;
        clr_long[gnt_idx] = 1'b1;
      end else begin
        gnt_type         = T_REL;
        clr_rel[gnt_idx] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flag update. A set wins over a same-cycle clear; a set onto a flag
  // that stays 1 merges the event and marks it lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    p_press_d = (p_press_q & ~clr_press) | rise;
    p_rel_d   = (p_rel_q   & ~clr_rel)   | fall;
    p_long_d  = (p_long_q  & ~clr_long)  | long_hit;
    ovf_d     = ovf_q
              | (rise     & p_press_q & ~clr_press)
              | (fall     & p_rel_q   & ~clr_rel)
              | (long_hit & p_long_q  & ~clr_long);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      p_press_q <= '0;
      p_rel_q   <= '0;
      p_long_q  <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt_q[i] <= '0;
      end
    end else begin
      prev_q     <= btn_db;
      p_press_q  <= p_press_d;
      p_rel_q    <= p_rel_d;
      p_long_q   <= p_long_d;
      ovf_q      <= ovf_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_type_q  <= T_PRESS;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            evt_ch_q    <= gnt_idx;
            evt_type_q  <= gnt_type;
            rr_ptr_q    <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + IW'(1);
            evt_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_type  = evt_type_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_db_event_arbiter.sv
// Purpose : self-checking bench for db_event_arbiter (N_BTN=4, LONG_LIMIT=8).
// Latency : model predicts each grant on the edge it happens; monitor checks
//           the presented event every cycle against the queue head.
// Backpressure: evt_ready driven directed and random; model tracks stalls.
module tb_db_event_arbiter;

  localparam int N  = 4;
  localparam int LL = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] btn_db;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_ch;
  logic [1:0]   evt_type;
  logic [N-1:0] ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  db_event_arbiter #(.N_BTN(N), .LONG_LIMIT(LL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_db    (btn_db),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_type  (evt_type),
    .ovf       (ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-channel sets of pending event kinds, an unbounded
  // run length of high samples, and a "presenting" flag for the single port.
  // ---------------------------------------------------------------------------
  bit           m_prev [N];
  int           m_run  [N];
  bit           m_pp   [N];
  bit           m_pl   [N];
  bit           m_pr   [N];
  bit           m_busy;
  int           m_rr;
  logic [N-1:0] m_ovf;
  logic [3:0]   exp_q [$];   // {channel, type}

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_run[i] = 0; m_pp[i] = 0; m_pl[i] = 0; m_pr[i] = 0;
    end
    m_busy = 0;
    m_rr   = 0;
    m_ovf  = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int g;
    bit b;
    if (m_busy) begin
      if (evt_ready) m_busy = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && (m_pp[c] || m_pl[c] || m_pr[c])) g = c;
      end
      if (g >= 0) begin
        if (m_pp[g]) begin
          exp_q.push_back({2'(g), 2'b00}); m_pp[g] = 0;
        end else if (m_pl[g]) begin
          exp_q.push_back({2'(g), 2'b10}); m_pl[g] = 0;
        end else begin
          exp_q.push_back({2'(g), 2'b01}); m_pr[g] = 0;
        end
        m_rr   = (g + 1) % N;
        m_busy = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      b = btn_db[i];
      if (b && !m_prev[i]) begin
        if (m_pp[i]) m_ovf[i] = 1'b1;
        m_pp[i] = 1;
      end
      if (!b && m_prev[i]) begin
        if (m_pr[i]) m_ovf[i] = 1'b1;
        m_pr[i] = 1;
      end
      m_run[i] = b ? m_run[i] + 1 : 0;
      if (m_run[i] == LL) begin
        if (m_pl[i]) m_ovf[i] = 1'b1;
        m_pl[i] = 1;
      end
      m_prev[i] = b;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: samples mid-cycle, compares against the queue head, pops on
  // handshake.
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      #1;
      check("valid_vs_model", int'(evt_valid), int'(m_busy));
      check("ovf_vs_model", int'(ovf), int'(m_ovf));
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got ch %0d type %0d, expected none at %0t",
                   evt_ch, evt_type, $time);
        end else begin
          e = exp_q[0];
          check("evt_ch", int'(evt_ch), int'(e[3:2]));
          check("evt_type", int'(evt_type), int'(e[1:0]));
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    btn_db    = '0;
    evt_ready = 1'b0;
    #2 rst_n  = 1'b0;

    // Reset values
    cyc(3); #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_ch", int'(evt_ch), 0);
    check("rst_type", int'(evt_type), 0);
    check("rst_ovf", int'(ovf), 0);

    // Release with ch2 held: press appears two edges later
    @(negedge clk);
    btn_db[2] = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    check("lat_edge1_valid", int'(evt_valid), 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", int'(evt_valid), 1);
    check("lat_ch", int'(evt_ch), 2);
    check("lat_type", int'(evt_type), 0);
    @(negedge clk);
    evt_ready = 1'b1;
    btn_db[2] = 1'b0;
    cyc(6);

    // Short press on ch1
    btn_db[1] = 1'b1; cyc(5);
    btn_db[1] = 1'b0; cyc(6);
    check("short_ovf", int'(ovf), 0);

    // Long press on ch0
    btn_db[0] = 1'b1; cyc(20);
    btn_db[0] = 1'b0; cyc(6);

    // Pulse ch3 so the pointer wraps to 0, then a simultaneous rise
    btn_db[3] = 1'b1; cyc(3);
    btn_db[3] = 1'b0; cyc(6);
    btn_db = 4'b1011; cyc(5);
    btn_db = 4'b0000; cyc(12);

    // Pulse ch0 so the pointer sits at 1, repeat the simultaneous rise
    btn_db[0] = 1'b1; cyc(3);
    btn_db[0] = 1'b0; cyc(6);
    btn_db = 4'b1011; cyc(5);
    btn_db = 4'b0000; cyc(12);

    // Stall with ch3 presented while ch2 toggles twice
    evt_ready = 1'b0;
    btn_db[3] = 1'b1; cyc(3);
    btn_db[2] = 1'b1; cyc(2);
    btn_db[2] = 1'b0; cyc(2);
    btn_db[2] = 1'b1; cyc(2);
    btn_db[2] = 1'b0; cyc(2);
    #1;
    check("stall_ovf2", int'(ovf[2]), 1);
    check("stall_valid", int'(evt_valid), 1);
    check("stall_ch", int'(evt_ch), 3);
    @(negedge clk);
    evt_ready = 1'b1; cyc(15);
    btn_db[3] = 1'b0; cyc(8);

    // Reset while an event is presented and others are pending
    evt_ready = 1'b0;
    btn_db = 4'b0110; cyc(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(evt_valid), 0);
    check("midrst_ovf", int'(ovf), 0);
    cyc(2);
    btn_db = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cyc(10);
    btn_db = 4'b0000; cyc(6);

    // Random traffic with random backpressure
    repeat (2000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) btn_db[i] = ~btn_db[i];
      end
      evt_ready = ($urandom_range(3) != 0);
    end

    // Drain
    @(negedge clk);
    btn_db    = '0;
    evt_ready = 1'b1;
    cyc(60);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid", int'(evt_valid), 0);
    check("final_ovf", int'(ovf), int'(m_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
